// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between the instruction-fetch and load/store ports.
// One access at a time; each access occupies MEM_LAT cycles and completes with a one-cycle rvalid pulse.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int FAIR    = 1
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic [AW-1:0] m_adr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    // Handshake: a requester holds req and its request fields stable until gnt;
    // gnt is a same-cycle combinational accept, and rvalid is a one-cycle pulse
    // MEM_LAT+1 cycles later. A req dropped before gnt simply never happens.

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_owner_d;
    logic          r_is_store;
    logic          r_rr_d;
    logic          r_m_we;
    logic [AW-1:0] r_m_adr;
    logic [DW-1:0] r_m_wdata;
    logic          r_i_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_idle;
    logic          w_pick_d;
    logic          w_i_gnt;
    logic          w_d_gnt;
    logic          w_last;

    // Gating with reset keeps the combinational grants low while reset is asserted.
    assign w_idle   = (r_state == IDLE) && reset;
    assign w_pick_d = d_req && (!i_req || (FAIR == 0) || r_rr_d);
    assign w_d_gnt  = w_idle && w_pick_d;
    assign w_i_gnt  = w_idle && i_req && !w_pick_d;
    assign w_last   = (r_cnt == 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_owner_d  <= 1'b0;
            r_is_store <= 1'b0;
            r_rr_d     <= 1'b1;
            r_m_we     <= 1'b0;
            r_m_adr    <= '0;
            r_m_wdata  <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_m_we     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_gnt || w_i_gnt) begin
                        r_state    <= ACCESS;
                        r_cnt      <= LAT;
                        r_owner_d  <= w_d_gnt;
                        r_is_store <= w_d_gnt && d_we;
                        r_m_we     <= w_d_gnt && d_we;
                        r_m_adr    <= w_d_gnt ? d_adr : i_adr;
                        // fetch has no write data, so m_wdata keeps its previous value
                        if (w_d_gnt) begin
                            r_m_wdata <= d_wdata;
                        end
                        r_rr_d     <= !w_d_gnt;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_state <= IDLE;
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_is_store ? '0 : m_rdata;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= m_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign m_adr    = r_m_adr;
    assign m_we     = r_m_we;
    assign m_wdata  = r_m_wdata;
    assign busy     = (r_state == ACCESS);

endmodule
